// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// Holds the FSM encoding and the round-robin successor helper.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_DSIZE    = 8;
    localparam int DEF_NREQ     = 4;
    localparam int DEF_MAXBURST = 8;

    function automatic int rr_next(input int idx, input int nreq);
        return (idx >= nreq - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
// Zero latency, no state, no backpressure.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [IDXW-1:0] o_idx,
    output logic            o_any
);

    logic [IDXW:0]   w_sum;
    logic [IDXW-1:0] w_c;
    logic            w_found;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        w_sum    = '0;
        w_c      = '0;
        for (int k = 0; k < NREQ; k++) begin
            // i_ptr < NREQ, so one conditional subtract is enough to wrap
            w_sum = {1'b0, i_ptr} + (IDXW+1)'(k);
            if (w_sum >= (IDXW+1)'(NREQ)) begin
                w_sum = w_sum - (IDXW+1)'(NREQ);
            end
            w_c = w_sum[IDXW-1:0];
            if (!w_found && i_req[w_c]) begin
                w_found      = 1'b1;
                o_onehot[w_c] = 1'b1;
                o_idx        = w_c;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of the async FIFO write port; grant one cycle after valid in IDLE,
// one word per cycle in BURST, all requesters and winc held off while wfull is high.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DSIZE    = DEF_DSIZE,
    parameter int NREQ     = DEF_NREQ,
    parameter int MAXBURST = DEF_MAXBURST
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [NREQ-1:0]       grant,
    output logic                  busy
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = $clog2(MAXBURST + 1);

    arb_state_t      r_state, w_state_nxt;
    logic [NREQ-1:0] r_grant, w_grant_nxt;
    logic [IDXW-1:0] r_gidx, w_gidx_nxt;
    logic [IDXW-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic [CNTW-1:0] r_cnt, w_cnt_nxt;

    logic [NREQ-1:0] w_pick_oh;
    logic [IDXW-1:0] w_pick_idx;
    logic            w_pick_any;
    logic            w_xfer;
    logic            w_end;

    logic [DSIZE-1:0] w_word [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_word
        assign w_word[i] = req_data[i*DSIZE +: DSIZE];
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .i_req    (req_valid),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_gidx   <= w_gidx_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_gidx_nxt   = r_gidx;
        w_rr_ptr_nxt = r_rr_ptr;
        w_cnt_nxt    = r_cnt;
        req_ready    = '0;
        winc         = 1'b0;
        busy         = 1'b0;
        w_xfer       = 1'b0;
        w_end        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = BURST;
                    w_grant_nxt = w_pick_oh;
                    w_gidx_nxt  = w_pick_idx;
                    w_cnt_nxt   = '0;
                end
            end
            BURST: begin
                busy      = 1'b1;
                req_ready = r_grant & {NREQ{~wfull}};
                w_xfer    = req_valid[r_gidx] & ~wfull;
                winc      = w_xfer;
                if (w_xfer) begin
                    w_cnt_nxt = r_cnt + CNTW'(1);
                    // last and the cap landing together still end the burst only once
                    w_end = req_last[r_gidx] | (r_cnt == CNTW'(MAXBURST - 1));
                    if (w_end) begin
                        w_state_nxt  = IDLE;
                        w_grant_nxt  = '0;
                        w_rr_ptr_nxt = IDXW'(rr_next(int'(r_gidx), NREQ));
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    assign grant = r_grant;
    assign wdata = (r_state == BURST) ? w_word[r_gidx] : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: transaction-level model predicts grants and FIFO writes,
// a negedge monitor pops the expected-write queue whenever winc is seen.
module tb_fifo_wr_arbiter;

    localparam int DSIZE    = 8;
    localparam int NREQ     = 4;
    localparam int MAXBURST = 8;

    logic                  wclk = 1'b0;
    logic                  wrst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [NREQ-1:0]       grant;
    logic                  busy;

    fifo_wr_arbiter #(
        .DSIZE    (DSIZE),
        .NREQ     (NREQ),
        .MAXBURST (MAXBURST)
    ) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 wclk = ~wclk;

    int n_chk  = 0;
    int n_fail = 0;

    // per-requester pending words {last, data}
    logic [DSIZE:0]   rq [NREQ][$];
    // expected FIFO writes {owner, data}
    logic [DSIZE+3:0] exp_wr [$];
    logic [DSIZE+3:0] mon_e;

    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;

    logic [NREQ-1:0] exp_grant = '0;
    logic [NREQ-1:0] exp_ready = '0;
    logic            exp_winc  = 1'b0;
    logic            mon_en    = 1'b0;

    int p_full    = 0;
    int p_gap     = 0;
    int full_hold = 0;
    int gap_hold  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_burst(input int i, input int len);
        logic [DSIZE-1:0] d;
        for (int k = 0; k < len; k++) begin
            d = DSIZE'($urandom);
            rq[i].push_back({(k == len - 1), d});
        end
    endtask

    function automatic bit model_pending();
        if (m_owner >= 0) return 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Drive one cycle of inputs and advance the reference model across the coming edge.
    task automatic step();
        logic           gap;
        logic [DSIZE:0] w;
        @(posedge wclk);
        #1;
        if (full_hold > 0) begin
            wfull = 1'b1;
            full_hold--;
        end else begin
            wfull = ($urandom_range(0, 99) < p_full);
        end
        for (int i = 0; i < NREQ; i++) begin
            gap = (m_owner == i) && ((gap_hold > 0) || ($urandom_range(0, 99) < p_gap));
            req_valid[i] = (rq[i].size() > 0) && !gap;
            if (rq[i].size() > 0) begin
                req_data[i*DSIZE +: DSIZE] = rq[i][0][DSIZE-1:0];
                req_last[i]                = rq[i][0][DSIZE];
            end else begin
                req_data[i*DSIZE +: DSIZE] = '0;
                req_last[i]                = 1'b0;
            end
        end
        if (gap_hold > 0 && m_owner >= 0) gap_hold--;

        exp_grant = '0;
        exp_ready = '0;
        exp_winc  = 1'b0;
        if (m_owner >= 0) begin
            exp_grant[m_owner] = 1'b1;
            if (!wfull) exp_ready[m_owner] = 1'b1;
            if (req_valid[m_owner] && !wfull) begin
                w = rq[m_owner].pop_front();
                exp_winc = 1'b1;
                exp_wr.push_back({4'(m_owner), w[DSIZE-1:0]});
                m_cnt++;
                if (w[DSIZE] || m_cnt == MAXBURST) begin
                    m_ptr   = (m_owner + 1) % NREQ;
                    m_owner = -1;
                end
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (m_owner < 0 && req_valid[(m_ptr + k) % NREQ]) begin
                    m_owner = (m_ptr + k) % NREQ;
                    m_cnt   = 0;
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (model_pending() && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: still pending after %0d cycles, required idle", n);
        end
        run(2);
    endtask

    always @(negedge wclk) begin
        if (mon_en && !wrst) begin
            chk("grant", 32'(grant), 32'(exp_grant));
            chk("busy", 32'(busy), 32'(exp_grant != '0));
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("winc", 32'(winc), 32'(exp_winc));
            if (exp_grant == '0) chk("wdata_idle", 32'(wdata), 32'(0));
            if (winc) begin
                chk("winc_while_full", 32'(wfull), 32'(0));
                if (exp_wr.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL wr_unexpected: winc with data 0x%0h, required no write", wdata);
                end else begin
                    mon_e = exp_wr.pop_front();
                    chk("wdata", 32'(wdata), 32'(mon_e[DSIZE-1:0]));
                    chk("wr_owner", 32'(grant), 32'(1) << mon_e[DSIZE+3:DSIZE]);
                end
            end
        end
    end

    initial begin
        wrst      = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        wfull     = 1'b0;
        #12;
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_winc", 32'(winc), 32'(0));
        chk("rst_ready", 32'(req_ready), 32'(0));
        chk("rst_wdata", 32'(wdata), 32'(0));
        @(negedge wclk);
        #2;
        wrst   = 1'b0;
        mon_en = 1'b1;

        // fairness: four requesters, two 2-word bursts each
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NREQ; i++) push_burst(i, 2);
        end
        drain(200);

        // cap: long burst from req2 competing with req3
        push_burst(2, 20);
        push_burst(3, 3);
        drain(200);

        // last lands on the MAXBURST-th word
        push_burst(1, MAXBURST);
        push_burst(0, 2);
        push_burst(2, 2);
        drain(200);

        // back-pressure mid-burst
        push_burst(0, 6);
        push_burst(1, 2);
        run(3);
        full_hold = 3;
        drain(200);

        // valid gap by the owner
        push_burst(1, 4);
        push_burst(3, 2);
        run(2);
        gap_hold = 2;
        drain(200);

        // reset while req0 is mid-burst
        push_burst(0, 10);
        run(4);
        @(posedge wclk);
        #1;
        wrst = 1'b1;
        #1;
        chk("midrst_grant", 32'(grant), 32'(0));
        chk("midrst_winc", 32'(winc), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_ready", 32'(req_ready), 32'(0));
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        exp_wr.delete();
        m_owner   = -1;
        m_ptr     = 0;
        m_cnt     = 0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        exp_grant = '0;
        exp_ready = '0;
        exp_winc  = 1'b0;
        @(negedge wclk);
        #2;
        wrst = 1'b0;
        push_burst(1, 2);
        drain(50);

        // randomized traffic with back-pressure and owner gaps
        p_full = 20;
        p_gap  = 15;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 15) begin
                automatic int r = $urandom_range(0, NREQ - 1);
                if (rq[r].size() < 24) push_burst(r, $urandom_range(1, 12));
            end
            step();
        end
        p_full = 10;
        p_gap  = 5;
        drain(3000);

        chk("scoreboard_empty", 32'(exp_wr.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the write port of the async FIFO among NREQ requesters in the write clock domain. Grants one requester at a time for a burst, drives the FIFO `winc`/`wdata`, and back-pressures every requester from the FIFO `wfull` flag. Sits directly in front of the FIFO write-pointer/full logic; all logic is on `wclk`.

## Interface
- DSIZE, 8: data width of one FIFO word.
- NREQ, 4: number of requesters (2..16).
- MAXBURST, 8: maximum words per grant before forced re-arbitration (1..255).

- wclk  in  1  write-domain clock, rising edge.
- wrst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester word valid.
- req_data  in  NREQ*DSIZE  per-requester word; requester i occupies bits [i*DSIZE +: DSIZE].
- req_last  in  NREQ  marks final word of requester's burst.
- req_ready  out  NREQ  per-requester accept; a word transfers when valid & ready.
- wfull  in  1  FIFO full flag (registered, from FIFO).
- winc  out  1  FIFO write strobe.
- wdata  out  DSIZE  FIFO write data.
- grant  out  NREQ  one-hot current owner; all-zero when idle.
- busy  out  1  high while in BURST.

## Operation
- FSM states: IDLE, BURST.
- IDLE: if any req_valid high, select winner by round-robin starting at rr_ptr (lowest index at or after rr_ptr, wrapping); register grant one-hot, clear burst_cnt, go BURST. No valid -> stay IDLE, grant = 0.
- BURST: req_ready[g] = ~wfull for granted g; all other req_ready = 0. winc = req_valid[g] & ~wfull; wdata = req_data[g] (combinational mux).
- Each transfer increments burst_cnt (width $clog2(MAXBURST+1)).
- Burst ends on a transfer with req_last[g] = 1, or on the transfer that makes burst_cnt == MAXBURST (whichever first; both same cycle = one end). On end: grant <= 0, rr_ptr <= g+1 modulo NREQ, go IDLE.
- Granted requester dropping req_valid mid-burst: grant held, no timeout; no winc issued.
- wfull high in BURST: req_ready and winc held low; state, grant, burst_cnt frozen.
- Non-granted requesters must hold valid/data stable until served; arbiter never drops their request.
- winc never asserted while wfull = 1, so the FIFO never sees a write when full.

## Timing
- Reset (async assert, sync-free release): state IDLE, grant 0, rr_ptr 0, burst_cnt 0, busy 0; req_ready 0, winc 0, wdata 0 (mux output forced to 0 when grant = 0).
- Arbitration latency: valid seen in IDLE at cycle n -> grant and busy high at n+1 -> first transfer possible at n+1.
- One IDLE bubble cycle between consecutive bursts (end at cycle m, earliest next grant registered at m+1, first transfer at m+2).
- Throughput within a burst: one word per cycle while valid & ~wfull.
- Reset mid-burst: grant cleared immediately; partially written burst is not rolled back.

## Structure
- Package fifo_arb_pkg: FSM state enum (IDLE, BURST), default DSIZE/NREQ/MAXBURST constants, function for next round-robin index.
- Sub-module rr_pick: purely combinational, inputs req vector and rr_ptr, outputs one-hot winner and its index; instantiated once in IDLE arbitration path.
- Top holds FSM, grant/rr_ptr/burst_cnt registers and data mux.

## Test plan
- Reset: assert wrst mid-burst with req0 granted -> grant 0, winc 0, busy 0 same cycle; after release req1 valid alone -> grant = 4'b0010 one cycle later.
- Fairness: all four valid continuously, each sends 2-word bursts (last on 2nd) -> grant order 0,1,2,3,0; each grant 2 winc pulses, one idle cycle between.
- MAXBURST cap: MAXBURST=8, req2 sends 20 words with no last, req3 also valid -> req2 gets 8 writes, then req3 granted, then req2 resumes.
- Back-pressure: wfull high for 3 cycles mid-burst -> winc and req_ready low those 3 cycles, burst_cnt unchanged, no data lost; writes resume cycle after wfull falls.
- Valid gap: granted req1 drops valid for 2 cycles -> grant held, no winc, other valid requesters not granted until req1 sends last.
- Last coincides with MAXBURST: 8th word carries last -> single burst end, rr_ptr advances once.
